streamif_read_engine: RTL and testbench

Per-hardware-thread read channel that sits directly downstream of the StreamIF control register block. Takes the page address, address-valid and start controls for one read slot, fetches exactly one 4096-byte page from memory in fixed-length bursts, and presents the words as a 32-bit valid/ready stream to the hardware thread. Reports completion through its Idle output, which the control block reflects back to software.

---
 rtl/streamif_pkg.sv | 21 ++
 rtl/streamif_fifo.sv | 58 +++++
 rtl/streamif_read_engine.sv | 152 +++++++++++++++
 tb/tb_streamif_read_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/streamif_pkg.sv
// Shared StreamIF definitions for the read engine and the future write engine.
// Page geometry, word width and the engine state encoding live here.
package streamif_pkg;

   localparam int STREAMIF_WORD_W     = 32;
   localparam int STREAMIF_PAGE_BYTES = 4096;
   localparam int STREAMIF_PAGE_WORDS = 1024;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CREDIT,
      REQ,
      DATA,
      DRAIN
   } streamif_state_e;

   function automatic int streamif_burst_count(input int burst_len);
      return STREAMIF_PAGE_WORDS / burst_len;
   endfunction

endpackage

// File: rtl/streamif_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head word whenever not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module streamif_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   // Zero when empty so the output port has a defined value out of reset.
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/streamif_read_engine.sv
// StreamIF read channel: fetches one 4 KB page in fixed bursts (one outstanding)
// and streams the words to the hardware thread through a credit-checked FIFO.
module streamif_read_engine
   import streamif_pkg::*;
#(
   parameter int C_BURST_LEN  = 16,
   parameter int C_FIFO_DEPTH = 32
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [31:0] StreamIF_CTRL_Addr,
   input  logic        StreamIF_CTRL_AddrValid,
   input  logic        StreamIF_CTRL_Start,
   output logic        StreamIF_CTRL_Idle,
   output logic [31:0] M_REQ_ADDR,
   output logic [7:0]  M_REQ_LEN,
   output logic        M_REQ_VALID,
   input  logic        M_REQ_READY,
   input  logic [31:0] M_RDATA,
   input  logic        M_RVALID,
   input  logic        M_RLAST,
   output logic        M_RREADY,
   output logic [31:0] STREAM_DATA,
   output logic        STREAM_VALID,
   input  logic        STREAM_READY
);

   localparam int NUM_BURSTS  = streamif_burst_count(C_BURST_LEN);
   localparam int BURST_BYTES = C_BURST_LEN * (STREAMIF_WORD_W / 8);
   localparam int CW          = $clog2(C_FIFO_DEPTH+1);
   localparam int BCW         = $clog2(NUM_BURSTS+1);
   localparam int BTW         = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;

   streamif_state_e state;
   logic            start_d;
   logic [19:0]     base_pg;
   logic [11:0]     page_off;
   logic [BCW-1:0]  burst_cnt;
   logic [BTW-1:0]  beat_cnt;
   logic            idle_q;
   logic            req_valid_q;
   logic [31:0]     req_addr_q;

   logic            trigger;
   logic            beat_acc;
   logic            stream_pop;
   logic            credit_ok;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic            unused_bits;

   // RLAST is redundant with the beat counter; the low address bits are zero by contract.
   assign unused_bits = M_RLAST ^ (|StreamIF_CTRL_Addr[11:0]);

   assign trigger    = StreamIF_CTRL_Start & ~start_d;
   assign M_RREADY   = (state == DATA) & ~fifo_full;
   assign beat_acc   = M_RVALID & M_RREADY;
   assign stream_pop = STREAM_VALID & STREAM_READY;
   assign credit_ok  = (int'(fifo_count) + C_BURST_LEN) <= C_FIFO_DEPTH;

   assign StreamIF_CTRL_Idle = idle_q;
   assign M_REQ_VALID        = req_valid_q;
   assign M_REQ_ADDR         = req_addr_q;
   assign M_REQ_LEN          = 8'(C_BURST_LEN - 1);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state       <= IDLE;
         start_d     <= 1'b0;
         base_pg     <= '0;
         page_off    <= '0;
         burst_cnt   <= '0;
         beat_cnt    <= '0;
         idle_q      <= 1'b1;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
      end else begin
         start_d <= StreamIF_CTRL_Start;
         case (state)
            IDLE: begin
               if (StreamIF_CTRL_AddrValid) base_pg <= StreamIF_CTRL_Addr[31:12];
               if (trigger) begin
                  state     <= WAIT_CREDIT;
                  idle_q    <= 1'b0;
                  page_off  <= '0;
                  burst_cnt <= '0;
               end
            end
            // Only request once the whole burst is guaranteed a FIFO slot.
            WAIT_CREDIT: begin
               if (credit_ok) begin
                  state       <= REQ;
                  req_valid_q <= 1'b1;
                  req_addr_q  <= {base_pg, page_off};
                  beat_cnt    <= '0;
               end
            end
            REQ: begin
               if (M_REQ_READY) begin
                  state       <= DATA;
                  req_valid_q <= 1'b0;
               end
            end
            DATA: begin
               if (beat_acc) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == BTW'(C_BURST_LEN-1)) begin
                     beat_cnt <= '0;
                     page_off <= page_off + 12'(BURST_BYTES);
                     if (burst_cnt == BCW'(NUM_BURSTS-1)) begin
                        state <= DRAIN;
                     end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                        state     <= WAIT_CREDIT;
                     end
                  end
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state  <= IDLE;
                  idle_q <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               idle_q      <= 1'b1;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   streamif_fifo #(
      .WIDTH (STREAMIF_WORD_W),
      .DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (beat_acc),
      .din   (M_RDATA),
      .pop   (stream_pop),
      .dout  (STREAM_DATA),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign STREAM_VALID = ~fifo_empty;

endmodule

// File: tb/tb_streamif_read_engine.sv
// Scoreboard bench for streamif_read_engine: a random-latency memory model serves
// bursts, expected requests/words are queued at page start and checked by a monitor.
module tb_streamif_read_engine;

   localparam int BL    = 16;
   localparam int DEPTH = 32;
   localparam int NB    = 1024 / BL;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [31:0] StreamIF_CTRL_Addr = '0;
   logic        StreamIF_CTRL_AddrValid = 1'b0;
   logic        StreamIF_CTRL_Start = 1'b0;
   logic        StreamIF_CTRL_Idle;
   logic [31:0] M_REQ_ADDR;
   logic [7:0]  M_REQ_LEN;
   logic        M_REQ_VALID;
   logic        M_REQ_READY;
   logic [31:0] M_RDATA;
   logic        M_RVALID;
   logic        M_RLAST;
   logic        M_RREADY;
   logic [31:0] STREAM_DATA;
   logic        STREAM_VALID;
   logic        STREAM_READY;

   always #5 ACLK = ~ACLK;

   streamif_read_engine #(.C_BURST_LEN(BL), .C_FIFO_DEPTH(DEPTH)) dut (
      .ACLK                    (ACLK),
      .ARESET                  (ARESET),
      .StreamIF_CTRL_Addr      (StreamIF_CTRL_Addr),
      .StreamIF_CTRL_AddrValid (StreamIF_CTRL_AddrValid),
      .StreamIF_CTRL_Start     (StreamIF_CTRL_Start),
      .StreamIF_CTRL_Idle      (StreamIF_CTRL_Idle),
      .M_REQ_ADDR              (M_REQ_ADDR),
      .M_REQ_LEN               (M_REQ_LEN),
      .M_REQ_VALID             (M_REQ_VALID),
      .M_REQ_READY             (M_REQ_READY),
      .M_RDATA                 (M_RDATA),
      .M_RVALID                (M_RVALID),
      .M_RLAST                 (M_RLAST),
      .M_RREADY                (M_RREADY),
      .STREAM_DATA             (STREAM_DATA),
      .STREAM_VALID            (STREAM_VALID),
      .STREAM_READY            (STREAM_READY)
   );

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] exp_word_q[$];
   logic [31:0] exp_req_q[$];
   logic [31:0] burst_q[$];
   int          occ = 0;
   int          words_seen = 0;
   int          req_seen = 0;
   int          idle_chk = 0;
   int          ready_duty = 100;
   int          req_delay = 0;
   int          rgap = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        prev_sstall = 1'b0;
   logic [31:0] prev_sdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge what will happen at the next rising edge.
   always @(negedge ACLK) begin : monitor
      logic s_hs;
      logic b_hs;
      if (ARESET) begin
         idle_chk    = 0;
         prev_stall  = 1'b0;
         prev_sstall = 1'b0;
      end else begin
         if (idle_chk == 2) begin
            check("busy_until_last_pop", StreamIF_CTRL_Idle, 1'b0);
            idle_chk = 1;
         end else if (idle_chk == 1) begin
            check("idle_after_last_pop", StreamIF_CTRL_Idle, 1'b1);
            idle_chk = 0;
         end
         check("valid_vs_occupancy", STREAM_VALID, occ != 0);
         s_hs = STREAM_VALID & STREAM_READY;
         b_hs = M_RVALID & M_RREADY;
         if (M_RREADY) check("rready_not_full", occ < DEPTH, 1'b1);
         if (prev_sstall) begin
            check("stream_valid_hold", STREAM_VALID, 1'b1);
            check("stream_data_hold", STREAM_DATA, prev_sdata);
         end
         if (s_hs) begin
            words_seen++;
            if (exp_word_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%08h, expected none", STREAM_DATA);
            end else begin
               check("stream_word", STREAM_DATA, exp_word_q.pop_front());
               if (exp_word_q.size() == 0) idle_chk = 2;
            end
         end
         if (prev_stall) begin
            check("req_valid_hold", M_REQ_VALID, 1'b1);
            check("req_addr_hold", M_REQ_ADDR, prev_addr);
         end
         if (M_REQ_VALID & M_REQ_READY) begin
            req_seen++;
            check("req_len", M_REQ_LEN, BL-1);
            check("req_credit", occ <= DEPTH-BL, 1'b1);
            if (exp_req_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_req: got 0x%08h, expected none", M_REQ_ADDR);
            end else begin
               check("req_addr", M_REQ_ADDR, exp_req_q.pop_front());
            end
         end
         prev_stall  = M_REQ_VALID & ~M_REQ_READY;
         prev_addr   = M_REQ_ADDR;
         prev_sstall = STREAM_VALID & ~STREAM_READY;
         prev_sdata  = STREAM_DATA;
         occ = occ + int'(b_hs) - int'(s_hs);
      end
   end

   // Memory model: one data word per byte address, random request and beat latency.
   initial begin : mem_model
      logic        req_hs;
      logic        beat_hs;
      logic [31:0] req_a;
      int          cur_beat;
      int          wait_cnt;
      cur_beat = 0;
      wait_cnt = 0;
      M_REQ_READY = 1'b0;
      M_RVALID = 1'b0;
      M_RDATA = '0;
      M_RLAST = 1'b0;
      forever begin
         @(negedge ACLK);
         req_hs  = M_REQ_VALID & M_REQ_READY;
         req_a   = M_REQ_ADDR;
         beat_hs = M_RVALID & M_RREADY;
         @(posedge ACLK);
         #1;
         if (ARESET) begin
            burst_q.delete();
            cur_beat = 0;
            wait_cnt = 0;
            M_REQ_READY = 1'b0;
            M_RVALID = 1'b0;
            M_RLAST = 1'b0;
         end else begin
            if (req_hs) begin
               burst_q.push_back(req_a);
               M_REQ_READY = 1'b0;
               wait_cnt = 0;
            end else if (M_REQ_VALID && !M_REQ_READY) begin
               if (wait_cnt >= req_delay) M_REQ_READY = 1'b1;
               else wait_cnt++;
            end
            if (beat_hs) begin
               cur_beat++;
               if (cur_beat == BL) begin
                  void'(burst_q.pop_front());
                  cur_beat = 0;
               end
            end
            if (!(M_RVALID && !beat_hs)) begin
               if (burst_q.size() != 0 && $urandom_range(99) >= rgap) begin
                  M_RVALID = 1'b1;
                  M_RDATA  = burst_q[0] + 32'(cur_beat * 4);
                  M_RLAST  = (cur_beat == BL-1);
               end else begin
                  M_RVALID = 1'b0;
                  M_RLAST  = 1'b0;
               end
            end
         end
      end
   end

   initial begin : sink
      STREAM_READY = 1'b0;
      forever begin
         @(posedge ACLK);
         #1;
         STREAM_READY = ($urandom_range(99) < ready_duty);
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_idle"}, StreamIF_CTRL_Idle, 1'b1);
      check({tag, "_req_valid"}, M_REQ_VALID, 1'b0);
      check({tag, "_req_addr"}, M_REQ_ADDR, 32'h0);
      check({tag, "_req_len"}, M_REQ_LEN, BL-1);
      check({tag, "_rready"}, M_RREADY, 1'b0);
      check({tag, "_stream_valid"}, STREAM_VALID, 1'b0);
      check({tag, "_stream_data"}, STREAM_DATA, 32'h0);
   endtask

   task automatic load_addr(input logic [31:0] addr);
      @(negedge ACLK);
      StreamIF_CTRL_Addr = addr;
      StreamIF_CTRL_AddrValid = 1'b1;
      @(negedge ACLK);
      StreamIF_CTRL_AddrValid = 1'b0;
   endtask

   // Queue the page's expected requests and words, then raise Start.
   task automatic start_page(input logic [31:0] addr, input bit with_av, input bit hold);
      logic [31:0] base;
      base = {addr[31:12], 12'h000};
      for (int b = 0; b < NB; b++) exp_req_q.push_back(base + 32'(b * BL * 4));
      for (int i = 0; i < 1024; i++) exp_word_q.push_back(base + 32'(i * 4));
      @(negedge ACLK);
      if (with_av) begin
         StreamIF_CTRL_Addr = addr;
         StreamIF_CTRL_AddrValid = 1'b1;
      end
      StreamIF_CTRL_Start = 1'b1;
      @(negedge ACLK);
      StreamIF_CTRL_AddrValid = 1'b0;
      if (!hold) StreamIF_CTRL_Start = 1'b0;
      check("idle_drops", StreamIF_CTRL_Idle, 1'b0);
      check("req_valid_t1", M_REQ_VALID, 1'b0);
      @(negedge ACLK);
      check("req_valid_t2", M_REQ_VALID, 1'b1);
   endtask

   task automatic wait_done(input string name, output int cycles);
      int n;
      n = 0;
      while (!(exp_word_q.size() == 0 && StreamIF_CTRL_Idle) && n < 30000) begin
         @(negedge ACLK);
         n++;
      end
      check({name, "_completes"}, n < 30000, 1'b1);
      check({name, "_reqs_left"}, exp_req_q.size(), 0);
      check({name, "_words_left"}, exp_word_q.size(), 0);
      cycles = n;
   endtask

   task automatic wait_words(input int count);
      int w0;
      int n;
      w0 = words_seen;
      n = 0;
      while (words_seen - w0 < count && n < 20000) begin
         @(negedge ACLK);
         n++;
      end
      check("reach_word_count", n < 20000, 1'b1);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int cyc;
      int vcnt;
      int r0;
      @(negedge ACLK);
      check_reset_values("in_reset");
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      check_reset_values("after_reset");

      // Quiescent: no Start, no requests.
      vcnt = 0;
      repeat (100) begin
         @(negedge ACLK);
         if (M_REQ_VALID) vcnt++;
      end
      check("no_req_without_start", vcnt, 0);
      check("idle_without_start", StreamIF_CTRL_Idle, 1'b1);

      // Basic page: address loaded separately, low bits must be dropped.
      load_addr(32'h1000_0ABC);
      start_page(32'h1000_0ABC, 1'b0, 1'b0);
      wait_done("basic", cyc);

      // Consumer backpressure, address loaded in the same cycle as the trigger.
      ready_duty = 25;
      start_page($urandom(), 1'b1, 1'b0);
      wait_done("backpressure", cyc);

      // Start edge and address load while busy are both ignored; held Start does not restart.
      ready_duty = 70;
      start_page(32'h1000_0ABC, 1'b1, 1'b1);
      wait_words(200);
      @(negedge ACLK);
      StreamIF_CTRL_Start = 1'b0;
      @(negedge ACLK);
      StreamIF_CTRL_Start = 1'b1;
      StreamIF_CTRL_Addr = 32'h2000_0000;
      StreamIF_CTRL_AddrValid = 1'b1;
      @(negedge ACLK);
      StreamIF_CTRL_AddrValid = 1'b0;
      wait_done("busy_start", cyc);
      r0 = req_seen;
      vcnt = 0;
      repeat (100) begin
         @(negedge ACLK);
         if (M_REQ_VALID) vcnt++;
      end
      check("held_start_no_restart", vcnt, 0);
      check("held_start_no_req", req_seen - r0, 0);
      StreamIF_CTRL_Start = 1'b0;

      // Memory stalls; base must still be the first page's address.
      ready_duty = 100;
      req_delay = 5;
      rgap = 50;
      start_page(32'h1000_0000, 1'b0, 1'b0);
      wait_done("mem_stall", cyc);

      // Reset in the middle of a page.
      req_delay = 0;
      rgap = 20;
      start_page(32'h0555_5000, 1'b1, 1'b0);
      wait_words(300);
      @(posedge ACLK);
      #2;
      ARESET = 1'b1;
      exp_word_q.delete();
      exp_req_q.delete();
      occ = 0;
      @(negedge ACLK);
      check_reset_values("mid_reset");
      repeat (2) @(negedge ACLK);
      check("rready_low_in_reset", M_RREADY, 1'b0);
      ARESET = 1'b0;
      rgap = 0;
      @(negedge ACLK);
      check_reset_values("post_mid_reset");
      start_page(32'h3000_0000, 1'b1, 1'b0);
      wait_done("after_reset_page", cyc);
      check("full_speed_cycles_ok", (cyc + 2) <= 1024 + NB * 3 + 8, 1'b1);

      repeat (5) @(negedge ACLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
